rom_boot_loader: RTL and testbench
==================================

ROM_BOOT_LOADER -- requirements
Module: rom_boot_loader

Interface
REQ-001 Parameters SHALL be, one per line:
- CLKS_PER_BIT, 868, clk_100MHz cycles per UART bit (115200 baud).
- ADDR_W, 10, ROM word-address width.
- DEPTH, 1024, ROM depth in 32-bit words.

REQ-002 Ports SHALL be, one per line:
- clk_100MHz  in  1  system clock.
- arst  in  1  reset; asynchronous, active-high.
- uart_rx  in  1  serial input, 8N1, idle high.
- rom_we  out  1  ROM write strobe, one cycle per word.
- rom_addr  out  ADDR_W  ROM word address.
- rom_wdata  out  32  ROM write data.
- hold  out  1  CPU hold, drives the SoC hold input.
- load_done  out  1  one-cycle pulse on successful load.
- load_err  out  1  sticky error flag.

REQ-003 The design SHALL have one clock, clk_100MHz; arst is asynchronous and active-high.

Function
REQ-004 The UART receiver SHALL synchronise uart_rx through 2 flops.
REQ-005 The receiver SHALL detect a falling edge and sample at mid-bit (CLKS_PER_BIT/2).
REQ-006 The receiver SHALL reject a start bit that reads high at mid-bit as a glitch.
REQ-007 The receiver SHALL shift in 8 bits LSB-first and check the stop bit.
REQ-008 The receiver SHALL produce a one-cycle byte_valid with the received byte.
REQ-009 A byte with a low stop bit SHALL be discarded and SHALL set load_err.
REQ-010 The frame format SHALL be: sync byte 0xA5, word count N (16-bit, low byte first), then 4*N data bytes, each word little-endian.
REQ-011 FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, DONE.
REQ-012 IDLE SHALL ignore every byte except 0xA5, which moves to LEN_LO.
REQ-013 LEN_LO SHALL go to LEN_HI on the next byte.
REQ-014 From LEN_HI on the next byte: N==0 -> DONE; N>DEPTH -> set load_err and go to IDLE with no writes; otherwise -> DATA.
REQ-015 DATA SHALL assemble bytes into a 32-bit word; on the 4th byte it SHALL assert rom_we for exactly 1 cycle with rom_addr = word index and rom_wdata = assembled word.
REQ-016 The word index SHALL start at 0 and increment after each write; it SHALL never wrap because N<=DEPTH.
REQ-017 After word N-1 is written, DATA SHALL go to DONE.
REQ-018 DONE SHALL pulse load_done for 1 cycle and return to IDLE.
REQ-019 hold SHALL be high from the cycle after 0xA5 is accepted until the cycle load_done is high, inclusive.
REQ-020 hold SHALL drop the cycle after load_done; it SHALL also drop on return to IDLE via an error.
REQ-021 rom_we latency SHALL be 1 clk_100MHz cycle after the byte_valid of the 4th byte.
REQ-022 A 0xA5 received in LEN_LO, LEN_HI or DATA SHALL be treated as data, not as a resync.
REQ-023 load_err SHALL clear only on reset or on acceptance of the next sync byte.
REQ-024 A framing error during DATA SHALL set load_err, go to IDLE and drop hold; words already written are not rolled back.
REQ-025 The byte after an accepted frame's last word SHALL be handled in IDLE.

Reset
REQ-026 arst high SHALL immediately force: FSM=IDLE, receiver idle, word index 0.
REQ-027 arst high SHALL immediately force all outputs to 0, and the synchroniser flops to 1.
REQ-028 Reset mid-load SHALL abandon the frame with no further rom_we.
REQ-029 Outputs SHALL be registered; rom_addr and rom_wdata SHALL hold their last value while rom_we=0.

Structure
REQ-030 A shared package SHALL hold: SYNC_BYTE=8'hA5, the FSM state enum, and the default CLKS_PER_BIT/ADDR_W/DEPTH.
REQ-031 The byte receiver SHALL be a sub-module uart_rx (ports: clk_100MHz, arst, rx, byte_valid, byte_data, frame_err).
REQ-032 rom_boot_loader SHALL instantiate uart_rx once.
REQ-033 rom_boot_loader SHALL contain the frame FSM, word assembler and counters.

Verification (CLKS_PER_BIT=16)
REQ-034 Frame A5 02 00 78 56 34 12 EF BE AD DE -> rom_we at addr 0 data 32'h12345678, then addr 1 data 32'hDEADBEEF; load_done 1 cycle; hold high throughout, low after.
REQ-035 Bytes 00 FF then A5 00 00 -> no rom_we; hold high from sync to load_done; load_done once.
REQ-036 Frame A5 01 04 (N=1025) -> load_err=1, no rom_we, hold low, FSM in IDLE; then a valid 1-word frame -> load_err cleared, write at addr 0.
REQ-037 Frame A5 01 00 then 2 data bytes, then a byte with stop bit low -> load_err=1, no rom_we, hold low.
REQ-038 arst pulsed after 5 data bytes of an N=2 frame -> exactly one rom_we (addr 0), all outputs 0 after reset; next frame loads from addr 0.
REQ-039 A 1-cycle low glitch on uart_rx while idle -> no byte_valid and no state change.

Source files
------------

// File: rtl/rom_boot_loader_pkg.sv
// Shared constants and FSM state type for the UART ROM boot loader.
// Defaults target a 100 MHz clock at 115200 baud and a 1K-word ROM.
package rom_boot_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DEF_ADDR_W       = 10;
  localparam int DEF_DEPTH        = 1024;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    DONE
  } ld_state_t;

endpackage

// File: rtl/rom_boot_loader_uart_rx.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling, glitch-rejecting start detect.
// byte_valid/frame_err pulse one cycle at the mid-stop sample; no backpressure, bytes are never held.
module uart_rx
  import rom_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk_100MHz,
  input  logic       arst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  rx_state_t     st;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk_100MHz or posedge arst) begin
    if (arst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      st         <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (st)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            st  <= RX_START;
            cnt <= '0;
          end
        end
        RX_START: begin
          // A line that is high again at mid-start was a glitch, not a frame.
          if (cnt == HALF) begin
            cnt <= '0;
            if (rx_sync) begin
              st <= RX_IDLE;
            end else begin
              st      <= RX_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              st <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            st  <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rom_boot_loader.sv
// Loads a UART frame (A5, 16-bit word count, little-endian words) into ROM and holds the CPU meanwhile.
// rom_we fires 1 cycle after the 4th byte of each word; the serial link has no backpressure.
module rom_boot_loader
  import rom_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DEPTH        = DEF_DEPTH
) (
  input  logic              clk_100MHz,
  input  logic              arst,
  input  logic              uart_rx,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              hold,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  ld_state_t         state;
  logic [7:0]        len_lo;
  logic [15:0]       n_words;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_sr;
  logic [15:0]       len_rx;
  logic              last_word;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_100MHz(clk_100MHz),
    .arst      (arst),
    .rx        (uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  assign len_rx    = {byte_data, len_lo};
  assign last_word = ({1'b0, n_words} == (17'(word_idx) + 17'd1));

  always_ff @(posedge clk_100MHz or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      len_lo    <= '0;
      n_words   <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      word_sr   <= '0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      hold      <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      rom_we    <= 1'b0;
      load_done <= 1'b0;
      if (frame_err) begin
        // Words already written stay written; the frame is simply abandoned.
        load_err <= 1'b1;
        if (state != IDLE) begin
          state <= IDLE;
          hold  <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            hold <= 1'b0;
            if (byte_valid && byte_data == SYNC_BYTE) begin
              state    <= LEN_LO;
              hold     <= 1'b1;
              load_err <= 1'b0;
            end
          end
          LEN_LO: begin
            if (byte_valid) begin
              len_lo <= byte_data;
              state  <= LEN_HI;
            end
          end
          LEN_HI: begin
            if (byte_valid) begin
              n_words  <= len_rx;
              word_idx <= '0;
              byte_cnt <= '0;
              if (len_rx == 16'd0) begin
                state <= DONE;
              end else if ({1'b0, len_rx} > DEPTH_L) begin
                load_err <= 1'b1;
                hold     <= 1'b0;
                state    <= IDLE;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (byte_valid) begin
              byte_cnt <= byte_cnt + 2'd1;
              word_sr  <= {byte_data, word_sr[23:8]};
              if (byte_cnt == 2'd3) begin
                rom_we    <= 1'b1;
                rom_addr  <= word_idx;
                rom_wdata <= {byte_data, word_sr};
                word_idx  <= word_idx + 1'b1;
                if (last_word) begin
                  state <= DONE;
                end
              end
            end
          end
          DONE: begin
            // hold stays high through the load_done cycle and drops in IDLE.
            load_done <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_boot_loader.sv
// Scoreboard bench for rom_boot_loader: frame-level reference model feeds expected ROM writes and
// load_done events to a queue; a negedge monitor pops and compares whenever the DUT presents them.
module tb_rom_boot_loader;

  localparam int CPB   = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          clk_100MHz = 1'b0;
  logic          arst       = 1'b1;
  logic          uart_rx    = 1'b1;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_wdata;
  logic          hold;
  logic          load_done;
  logic          load_err;

  always #5 clk_100MHz = ~clk_100MHz;

  rom_boot_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW),
    .DEPTH       (DEPTH)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .arst      (arst),
    .uart_rx   (uart_rx),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .hold      (hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];
  int   done_pending = 0;
  logic ld_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or signals completion.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk_100MHz);
      if (arst) begin
        ld_prev = 1'b0;
      end else begin
        if (rom_we) begin
          check("we_with_hold", hold, 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0d data %08h, expected no write", rom_addr, rom_wdata);
          end else begin
            w = exp_q.pop_front();
            check("wr_addr", rom_addr, w.addr);
            check("wr_data", rom_wdata, w.data);
          end
        end
        if (load_done) begin
          check("done_expected", done_pending > 0, 1);
          check("done_with_hold", hold, 1);
          if (done_pending > 0) done_pending--;
        end
        if (ld_prev) check("hold_drop_after_done", hold, 0);
        ld_prev = load_done;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clk_100MHz);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk_100MHz);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk_100MHz);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk_100MHz);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk_100MHz);
  endtask

  // Reference model at frame level: word i of a complete frame lands at address i.
  task automatic send_body(input int n);
    logic [31:0] w;
    done_pending++;
    send_byte(8'(n), 1'b1);
    send_byte(8'(n >> 8), 1'b1);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if ($urandom_range(0, 2) == 0) w[15:8] = 8'hA5;
      exp_q.push_back({AW'(i), w});
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b1);
    end
  endtask

  task automatic send_frame(input int n);
    send_byte(8'hA5, 1'b1);
    send_body(n);
  endtask

  task automatic settle(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || done_pending != 0) && k < 3000) begin
      @(negedge clk_100MHz);
      k++;
    end
    check({tag, "_pending_writes"}, exp_q.size(), 0);
    check({tag, "_pending_done"}, done_pending, 0);
    exp_q.delete();
    done_pending = 0;
    repeat (4) @(negedge clk_100MHz);
  endtask

  logic [7:0] frame_a [11] = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                               8'hEF, 8'hBE, 8'hAD, 8'hDE};

  initial begin
    logic [31:0] w0;
    logic [7:0]  junk;
    int          n;

    // Reset state
    repeat (3) @(negedge clk_100MHz);
    check("reset_outputs", {rom_we, hold, load_done, load_err, rom_addr, rom_wdata}, 0);
    arst = 1'b0;
    repeat (5) @(negedge clk_100MHz);
    check("post_reset_outputs", {rom_we, hold, load_done, load_err, rom_addr, rom_wdata}, 0);

    // Two-word reference frame
    exp_q.push_back({AW'(0), 32'h12345678});
    exp_q.push_back({AW'(1), 32'hDEADBEEF});
    done_pending++;
    for (int i = 0; i < 11; i++) begin
      send_byte(frame_a[i], 1'b1);
      if (i == 4) check("hold_mid_frame", hold, 1);
    end
    settle("frame_a");
    check("frame_a_hold_after", hold, 0);
    check("frame_a_err", load_err, 0);
    check("frame_a_addr_held", rom_addr, 1);
    check("frame_a_data_held", rom_wdata, 32'hDEADBEEF);

    // Junk before sync, then a zero-length frame
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    check("junk_no_hold", hold, 0);
    send_byte(8'hA5, 1'b1);
    check("zero_len_hold_after_sync", hold, 1);
    done_pending++;
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    settle("zero_len");
    check("zero_len_hold_after", hold, 0);

    // Oversize length, then recovery with a one-word frame
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h04, 1'b1);
    repeat (10) @(negedge clk_100MHz);
    check("oversize_err", load_err, 1);
    check("oversize_hold", hold, 0);
    send_byte(8'hA5, 1'b1);
    check("resync_err_cleared", load_err, 0);
    check("resync_hold", hold, 1);
    send_body(1);
    settle("recover");
    check("recover_err", load_err, 0);

    // Framing error inside DATA
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    repeat (10) @(negedge clk_100MHz);
    check("framing_err", load_err, 1);
    check("framing_hold", hold, 0);
    settle("framing");

    // Reset in the middle of a two-word frame
    w0 = $urandom;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    exp_q.push_back({AW'(0), w0});
    for (int b = 0; b < 4; b++) send_byte(w0[8*b +: 8], 1'b1);
    send_byte(8'h5A, 1'b1);
    repeat (10) @(negedge clk_100MHz);
    check("midload_first_write", exp_q.size(), 0);
    arst = 1'b1;
    #1;
    check("midload_reset_outputs", {rom_we, hold, load_done, load_err, rom_addr, rom_wdata}, 0);
    repeat (3) @(negedge clk_100MHz);
    arst = 1'b0;
    repeat (5) @(negedge clk_100MHz);
    send_frame(2);
    settle("after_reset");

    // One-cycle low glitch while idle
    @(negedge clk_100MHz);
    uart_rx = 1'b0;
    @(negedge clk_100MHz);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk_100MHz);
    check("glitch_hold", hold, 0);
    check("glitch_err", load_err, 0);
    send_frame(1);
    settle("after_glitch");

    // Randomised frames with junk before and a trailing byte handled in IDLE
    for (int f = 0; f < 6; f++) begin
      junk = 8'($urandom_range(0, 255));
      if (junk == 8'hA5) junk = 8'h3C;
      send_byte(junk, 1'b1);
      n = $urandom_range(0, 4);
      send_frame(n);
      junk = 8'($urandom_range(0, 255));
      if (junk == 8'hA5) junk = 8'h00;
      send_byte(junk, 1'b1);
      settle("random");
      check("random_hold", hold, 0);
      check("random_err", load_err, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
